// File: rtl/pc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_ctrl
// Brief    : PC sequencer with return-address stack and one-cycle squash
//            bubble after every taken control transfer.
//            Optional macro PC_CTRL_RAS_TRAP_EN: RAS overflow/underflow traps
//            to HALT with sticky ras_err instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ctrl #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [15:0]     instr,
  input  logic            cond_true,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            halted,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // Opcode encodings shared with opcode.h
  localparam logic [3:0] OP_B    = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              halted_q, halted_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   ras_q [RAS_DEPTH];
  logic [PC_W-1:0]   ras_d [RAS_DEPTH];
`ifdef PC_CTRL_RAS_TRAP_EN
  logic              err_q, err_d;
`endif

  logic [PC_W-1:0]   pc_inc, br_tgt, call_tgt;
  logic [PTR_W-1:0]  ptr_inc, ptr_dec;
  logic              empty_w, full_w;

  assign pc_inc   = pc_q + PC_ONE;
  assign br_tgt   = pc_inc + {{(PC_W-8){instr[7]}}, instr[7:0]};
  assign call_tgt = pc_inc + {{(PC_W-12){instr[11]}}, instr[11:0]};
  assign ptr_inc  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
  assign ptr_dec  = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_ONE;
  assign empty_w  = (cnt_q == '0);
  assign full_w   = (cnt_q == CNT_FULL);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush_d  = flush_q;
    halted_d = halted_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ras_d    = ras_q;
`ifdef PC_CTRL_RAS_TRAP_EN
    err_d    = err_q;
`endif
    if (!stall) begin
      case (state_q)
        RUN: begin
          case (instr[15:12])
            OP_B: begin
              if (cond_true) begin
                pc_d    = br_tgt;
                state_d = BUBBLE;
              end else begin
                pc_d = pc_inc;
              end
            end
            OP_CALL: begin
`ifdef PC_CTRL_RAS_TRAP_EN
              if (full_w) begin
                err_d   = 1'b1;
                state_d = HALT;
              end else begin
                ras_d[ptr_q] = pc_inc;
                ptr_d        = ptr_inc;
                cnt_d        = cnt_q + CNT_ONE;
                pc_d         = call_tgt;
                state_d      = BUBBLE;
              end
`else
              // When full, ptr already addresses the oldest entry
              ras_d[ptr_q] = pc_inc;
              ptr_d        = ptr_inc;
              if (!full_w) cnt_d = cnt_q + CNT_ONE;
              pc_d         = call_tgt;
              state_d      = BUBBLE;
`endif
            end
            OP_RET: begin
              if (empty_w) begin
`ifdef PC_CTRL_RAS_TRAP_EN
                err_d   = 1'b1;
                state_d = HALT;
`else
                pc_d    = '0;
                state_d = BUBBLE;
`endif
              end else begin
                ptr_d   = ptr_dec;
                cnt_d   = cnt_q - CNT_ONE;
                pc_d    = ras_q[ptr_dec];
                state_d = BUBBLE;
              end
            end
            OP_HLT:  state_d = HALT;
            default: pc_d    = pc_inc;
          endcase
        end
        BUBBLE:  state_d = RUN;
        default: state_d = HALT;
      endcase
      flush_d  = (state_d == BUBBLE);
      halted_d = (state_d == HALT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= '0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset is needed here
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

`ifdef PC_CTRL_RAS_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign ras_err = err_q;
`else
  assign ras_err = 1'b0;
`endif

  assign pc        = pc_q;
  assign flush     = flush_q;
  assign halted    = halted_q;
  assign ras_empty = empty_w;
  assign ras_full  = full_w;

endmodule
`default_nettype wire

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter sequencer for the 16-bit core. It selects the next fetch address from the current instruction and the branch-condition bit produced by `flag_rf`. It keeps a hardware return-address stack (RAS) for CALL/RET and inserts a one-cycle squash bubble after every taken control transfer. It sits between instruction memory (combinational read of `instr` at `pc`) and the decode stage.

## Interface
- `PC_W`, 16: PC and address width.
- `RAS_DEPTH`, 4: return-address stack entries (≥2).

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  freeze all state (pc, FSM, RAS) this cycle.
- `instr`  in  16  instruction fetched at `pc`; opcode `instr[15:12]` per `opcode.h`.
- `cond_true`  in  1  branch-condition result from `flag_rf` for the current `instr`.
- `pc`  out  PC_W  fetch address.
- `flush`  out  1  registered; decode-stage instruction must be squashed.
- `halted`  out  1  core stopped.
- `ras_empty`  out  1  RAS holds 0 entries.
- `ras_full`  out  1  RAS holds RAS_DEPTH entries.
- `ras_err`  out  1  sticky RAS overflow/underflow (trap builds only).

## Operation
- FSM states: RUN, BUBBLE, HALT.
- RUN, `stall`=0, decode of `instr`:
  - `B`: offset = sext(`instr[7:0]`).
    - If `cond_true`=1: pc ← pc+1+offset, go to BUBBLE.
    - Else: pc ← pc+1, stay in RUN.
  - `CALL`: push pc+1; pc ← pc+1+sext(`instr[11:0]`); go to BUBBLE.
  - `RET`: pop; pc ← popped value; go to BUBBLE.
  - Opcode 4'hF (HLT): pc holds; go to HALT.
  - All other opcodes: pc ← pc+1.
- BUBBLE: `instr` is ignored. pc holds so the target is re-fetched. `flush`=1. Then go to RUN.
- HALT: pc holds and all inputs are ignored. Only `rst` exits HALT.
- `stall`=1 in any state: no change to pc, state, or RAS. `flush` holds its value.
- Arithmetic: all PC sums are modulo 2^PC_W. Offsets are sign-extended to PC_W.
- RAS storage:
  - Array of RAS_DEPTH × PC_W, a top-of-stack pointer, and a count of width clog2(RAS_DEPTH+1).
  - Push writes at ptr and then increments it. Pop decrements ptr and then reads.
  - Pointers wrap modulo RAS_DEPTH.

## Timing
- Reset values: pc=0, state=RUN, `flush`=0, `halted`=0, `ras_err`=0, count=0 (`ras_empty`=1, `ras_full`=0).
- Not-taken or sequential instruction: latency 1, a new pc every cycle.
- Taken B, CALL, or RET: the target pc appears at the next posedge. `flush`=1 for exactly the following cycle (the BUBBLE cycle). The first target instruction is executed in the cycle after that, so the penalty is one cycle.
- `flush` and `halted` are registered outputs and change only on posedge or on `rst`.
- `ras_empty` and `ras_full` are decoded from the registered count.
- `rst` asserted mid-BUBBLE or in HALT forces the reset values immediately and asynchronously. The RAS contents become don't-care, with count=0.
- `cond_true` is sampled only when the opcode is `B`. An X on `cond_true` for any other opcode has no effect.

## Configuration
`PC_CTRL_RAS_TRAP_EN`:
- **Defined:**
  - A push when full or a pop when empty sets `ras_err`=1 (sticky until `rst`) and goes to HALT.
  - The RAS is unchanged.
  - pc holds at the faulting instruction.
- **Undefined:**
  - A push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - A pop when empty sets pc ← 0 and goes to BUBBLE.
  - `ras_err` is tied to 0.

## Test plan
- **Taken branch:** reset, then force pc=0x0010; `instr`={`B`, x, `EQUAL`, 8'h05}, `cond_true`=1 → pc=0x0016. Next cycle `flush`=1 with pc=0x0016. Then pc=0x0017.
- **Not-taken and backward branch:**
  - Same instruction with `cond_true`=0 → pc=0x0011 and `flush` stays 0.
  - Offset 8'hFE from 0x0010 taken → pc=0x000F.
- **Call/return:**
  - CALL offset 12'h010 at pc=0x0020 → pc=0x0031, `ras_empty`=0.
  - After the bubble, RET → pc=0x0021, `ras_empty`=1.
- **Stall:** `stall`=1 for 3 cycles during BUBBLE → pc, `flush`=1 and state all frozen. Release → exactly one further `flush` cycle.
- **Overflow:** 5 nested CALLs with RAS_DEPTH=4.
  - With the trap macro: `ras_err`=1, `halted`=1, pc stuck at the 5th CALL.
  - Without it: 4 RETs return the last 4 pushed addresses, and the 5th RET → pc=0x0000.
- **Reset mid-operation:** assert `rst` between posedges during BUBBLE and separately in HALT → pc=0, `flush`=0, `halted`=0, `ras_empty`=1 immediately.
